// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
package pipe_pkg;

  localparam int unsigned PIPE_STAT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones until reset.
module pipe_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, 2-entry skid, stall hold, flush.
// Optional stall/flush statistics counters are enabled with `define PIPE_STAGE_STATS_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [PIPE_STAT_CNT_W-1:0] stall_cnt_o,
  output logic [PIPE_STAT_CNT_W-1:0] flush_cnt_o
`endif
);

  pipe_state_e       state_q, state_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              accept, take;
  logic              load_main, load_skid, main_from_skid;

  assign accept = in_valid_i & in_ready_q;
  assign take   = out_valid_o & out_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            state_d        = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Main keeps its contents after the entry leaves so out_data_o holds while invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (load_main) begin
      main_ctrl_q <= in_ctrl_i;
      main_data_q <= in_data_i;
    end else if (main_from_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (load_skid) begin
      skid_ctrl_q <= in_ctrl_i;
      skid_data_q <= in_data_i;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_ctrl_o  = out_valid_o ? main_ctrl_q : BUBBLE_CTRL;
  assign out_data_o  = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
  logic stall_en, flush_kill_en;

  assign stall_en      = out_valid_o & ~out_ready_i;
  assign flush_kill_en = flush_i & (state_q != ST_EMPTY);

  pipe_sat_cnt #(
    .Width (PIPE_STAT_CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_en),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(
    .Width (PIPE_STAT_CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_kill_en),
    .cnt_o (flush_cnt_o)
  );
`else
  // Statistics build option disabled: no counters.
`endif

endmodule
